wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Shares the register file's single 64-bit write port between two writeback sources: req0 (ALU writeback) and req1 (load/memory writeback).
- Uses round-robin arbitration with a valid/ready handshake on each requester.
- The selected write is captured in an output register, so it reaches the register file one clock after the grant.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DATA_W, 64, width of write data.
- ADDR_W, 5, width of register index (32 architectural registers).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  ADDR_W  requester 0 destination register.
- req0_data  input  DATA_W  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  ADDR_W  requester 1 destination register.
- req1_data  input  DATA_W  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle (combinational).
- wr_stall  input  1  register file cannot accept a write this cycle.
- wr_en  output  1  registered write strobe to the register file.
- wr_addr  output  ADDR_W  registered write index.
- wr_data  output  DATA_W  registered write data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0.
  - Priority pointer prio=0, meaning req0 is favoured.
  - req0_ready and req1_ready are forced to 0 while rst_n is low.
- Arbitration is combinational each cycle and only happens when wr_stall=0:
  - Exactly one requester valid: that requester is granted.
  - Both valid: the requester indicated by prio is granted.
  - Neither valid: no grant.
- wr_stall=1: no grant; both ready outputs are 0; prio holds; outputs are unchanged except that wr_en is cleared to 0 at the next edge.
- Handshake rules:
  - A transfer occurs when reqN_valid and reqN_ready are both 1 in the same cycle.
  - reqN_ready never depends on reqN_data.
  - A requester must hold valid, addr and data stable until its transfer occurs.
- Latency: on a granted cycle, the next rising edge loads wr_en=1, wr_addr and wr_data from the winner. Without a grant, the next edge loads wr_en=0 and addr/data hold their previous values.
- x0 handling: a granted write with addr==0 is accepted (ready=1) but the registered wr_en is 0; wr_addr and wr_data still update.
- Priority pointer update:
  - After a granted transfer, prio moves to the other requester, regardless of whether both were valid.
  - With no grant, prio holds.
- Both requesters targeting the same address in the same cycle: only the winner is written that cycle; the loser completes on a later cycle. No merging, no reordering within a requester.
- Back-to-back: a single requester holding valid continuously is granted every unstalled cycle; its ready is high in each cycle.
- Reset mid-operation: an in-flight grant is dropped and wr_en goes to 0 immediately; requesters re-present their writes after reset is released.

Optional Feature:
- Macro: WB_ARBITER_STATS_EN.
- Defined:
  - Adds output conflict_cnt [15:0], reset to 0.
  - Increments by 1 on each clock edge in which req0_valid=1, req1_valid=1 and wr_stall=0.
  - Saturates at 16'hFFFF.
- Not defined: the port and counter do not exist; arbitration behaviour is identical.

Test Plan:
- Reset, then req0_valid=1, addr=5, data=64'hDEAD_BEEF_0000_0001 -> req0_ready=1 in the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF_0000_0001.
- Both valid for 4 consecutive cycles, each holding valid until its own transfer -> grants alternate req0, req1, req0, req1; wr_addr sequence follows; with stats enabled, conflict_cnt=4.
- wr_stall=1 for 3 cycles with both valid -> both ready=0, wr_en=0, prio unchanged; on release the previously favoured requester wins first.
- req1_valid=1, addr=0, data=64'h1234 -> req1_ready=1; next cycle wr_en=0, wr_addr=0, wr_data=64'h1234.
- Both valid with addr=7, data0=64'hA, data1=64'hB after reset -> cycle 1 writes 64'hA, cycle 2 writes 64'hB to register 7.
- Assert rst_n=0 mid-cycle while wr_en=1 -> wr_en, wr_addr, wr_data go to 0 without waiting for a clock edge; after release, req0 is favoured.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the register file write port.
// The conflict_cnt signal exists only when WB_ARBITER_STATS_EN is defined.
interface wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef WB_ARBITER_STATS_EN
    logic [15:0]       conflict_cnt;
`endif

    modport slave (
`ifdef WB_ARBITER_STATS_EN
        output conflict_cnt,
`endif
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        input  wr_stall,
        output wr_en, wr_addr, wr_data
    );

    modport master (
`ifdef WB_ARBITER_STATS_EN
        input  conflict_cnt,
`endif
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        output wr_stall,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// Define WB_ARBITER_STATS_EN to add the saturating conflict_cnt output.
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

    prio_e             prio_q, prio_d;
    logic              grant0, grant1;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // Grants are gated by rst_n so both readies drop the moment reset asserts.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !bus.wr_stall) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = (prio_q == PRIO_REQ0);
                grant1 = (prio_q == PRIO_REQ1);
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_comb begin
        prio_d    = prio_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // Writes to x0 are accepted and captured, but never strobed into the register file.
        if (grant0) begin
            prio_d    = PRIO_REQ1;
            wr_en_d   = (bus.req0_addr != '0);
            wr_addr_d = bus.req0_addr;
            wr_data_d = bus.req0_data;
        end else if (grant1) begin
            prio_d    = PRIO_REQ0;
            wr_en_d   = (bus.req1_addr != '0);
            wr_addr_d = bus.req1_addr;
            wr_data_d = bus.req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= PRIO_REQ0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

`ifdef WB_ARBITER_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (bus.req0_valid && bus.req1_valid && !bus.wr_stall && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.conflict_cnt = conflict_cnt_q;
`endif

endmodule
